// File: rtl/ooo_flow_queue_driver.sv
// rtl/ooo_flow_queue_driver.sv - drives an OOO flow priority queue: enque pass-through, min service, max eviction
// Optional build macro OOO_DRIVER_TIMEOUT_EN adds a WAIT-state response watchdog driving timeout_err.
module ooo_flow_queue_driver #(
   parameter int MAX_NUM_OOO_FLOWS    = 64,
   parameter int OOO_FLOW_ID_AWIDTH   = 8,
   parameter int HEAP_PRIORITY_AWIDTH = 16,
   parameter int HEAP_SIZE_AWIDTH     = $clog2(MAX_NUM_OOO_FLOWS) + 1,
   parameter int EVICT_THRESHOLD      = MAX_NUM_OOO_FLOWS - 4,
   parameter int TIMEOUT_CYCLES       = 1024
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_insert_valid,
   input  logic [OOO_FLOW_ID_AWIDTH-1:0]   in_insert_ooo_flow_id,
   input  logic [HEAP_PRIORITY_AWIDTH-1:0] in_insert_priority,
   output logic                            in_insert_ready,
   input  logic                            in_evict_req,
   output logic                            q_enque_en,
   output logic [OOO_FLOW_ID_AWIDTH-1:0]   q_enque_ooo_flow_id,
   output logic [HEAP_PRIORITY_AWIDTH-1:0] q_enque_priority,
   input  logic                            q_enque_ready,
   output logic                            q_deque_min_en,
   input  logic                            q_deque_min_ready,
   input  logic [OOO_FLOW_ID_AWIDTH-1:0]   q_deque_min_ooo_flow_id,
   input  logic [HEAP_PRIORITY_AWIDTH-1:0] q_deque_min_priority,
   output logic                            q_deque_max_req_en,
   input  logic                            q_deque_max_req_ready,
   output logic                            q_deque_max_en,
   input  logic                            q_deque_max_ready,
   input  logic [OOO_FLOW_ID_AWIDTH-1:0]   q_deque_max_ooo_flow_id,
   input  logic [HEAP_PRIORITY_AWIDTH-1:0] q_deque_max_priority,
   input  logic [HEAP_SIZE_AWIDTH-1:0]     q_queue_size,
   output logic                            out_service_valid,
   output logic [OOO_FLOW_ID_AWIDTH-1:0]   out_service_ooo_flow_id,
   output logic [HEAP_PRIORITY_AWIDTH-1:0] out_service_priority,
   input  logic                            out_service_ready,
   output logic                            out_evict_valid,
   output logic [OOO_FLOW_ID_AWIDTH-1:0]   out_evict_ooo_flow_id,
   output logic [HEAP_PRIORITY_AWIDTH-1:0] out_evict_priority,
   input  logic                            out_evict_ready,
   output logic [31:0]                     evict_count,
   output logic [15:0]                     dropped_count,
   output logic                            timeout_err
);

   localparam logic [HEAP_SIZE_AWIDTH-1:0] THRESHOLD = HEAP_SIZE_AWIDTH'(EVICT_THRESHOLD);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} evict_state_t;

   evict_state_t state;
   logic         evict_pending;

   assign in_insert_ready     = q_enque_ready & ~rst;
   assign q_enque_en          = in_insert_valid & q_enque_ready & ~rst;
   assign q_enque_ooo_flow_id = in_insert_ooo_flow_id;
   assign q_enque_priority    = in_insert_priority;

   assign q_deque_min_en = ~rst & q_deque_min_ready & (~out_service_valid | out_service_ready);

   // A response seen outside WAIT is stale; it is drained in IDLE and never overlaps a new request.
   assign q_deque_max_req_en = ~rst & (state == ST_REQ) & ~q_deque_max_ready;
   assign q_deque_max_en     = ~rst & ((state == ST_WAIT) | ((state == ST_IDLE) & q_deque_max_ready));

   always_ff @(posedge clk) begin
      if (rst) begin
         out_service_valid       <= 1'b0;
         out_service_ooo_flow_id <= '0;
         out_service_priority    <= '0;
      end else if (q_deque_min_en) begin
         out_service_valid       <= 1'b1;
         out_service_ooo_flow_id <= q_deque_min_ooo_flow_id;
         out_service_priority    <= q_deque_min_priority;
      end else if (out_service_ready) begin
         out_service_valid <= 1'b0;
      end
   end

`ifdef OOO_DRIVER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (rst || state != ST_WAIT) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + TW'(1);
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= ST_IDLE;
         evict_pending         <= 1'b0;
         out_evict_valid       <= 1'b0;
         out_evict_ooo_flow_id <= '0;
         out_evict_priority    <= '0;
         evict_count           <= '0;
         dropped_count         <= '0;
`ifdef OOO_DRIVER_TIMEOUT_EN
         timeout_err           <= 1'b0;
`endif
      end else begin
         evict_pending <= evict_pending | in_evict_req;
         case (state)
            ST_IDLE: begin
               if (q_deque_max_ready) begin
                  if (dropped_count != 16'hFFFF) begin
                     dropped_count <= dropped_count + 16'd1;
                  end
               end else if (evict_pending || q_queue_size >= THRESHOLD) begin
                  state         <= ST_REQ;
                  evict_pending <= in_evict_req;
               end
            end
            ST_REQ: begin
               if (q_deque_max_req_en && q_deque_max_req_ready) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (q_deque_max_ready) begin
                  out_evict_valid       <= 1'b1;
                  out_evict_ooo_flow_id <= q_deque_max_ooo_flow_id;
                  out_evict_priority    <= q_deque_max_priority;
                  state                 <= ST_HOLD;
               end
`ifdef OOO_DRIVER_TIMEOUT_EN
               else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end
`endif
            end
            ST_HOLD: begin
               // Returning through IDLE lets the threshold see the post-eviction queue size.
               if (out_evict_ready) begin
                  out_evict_valid <= 1'b0;
                  evict_count     <= evict_count + 32'd1;
                  state           <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ooo_flow_queue_driver.sv
// tb/tb_ooo_flow_queue_driver.sv - directed and randomized scoreboard bench for ooo_flow_queue_driver
module tb_ooo_flow_queue_driver;

   localparam int MAXF = 16;
   localparam int IDW  = 8;
   localparam int PW   = 8;
   localparam int SW   = 5;
   localparam int THR  = 12;
   localparam int TMO  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic           in_insert_valid;
   logic [IDW-1:0] in_insert_ooo_flow_id;
   logic [PW-1:0]  in_insert_priority;
   logic           in_insert_ready;
   logic           in_evict_req;
   logic           q_enque_en;
   logic [IDW-1:0] q_enque_ooo_flow_id;
   logic [PW-1:0]  q_enque_priority;
   logic           q_enque_ready;
   logic           q_deque_min_en;
   logic           q_deque_min_ready;
   logic [IDW-1:0] q_deque_min_ooo_flow_id;
   logic [PW-1:0]  q_deque_min_priority;
   logic           q_deque_max_req_en;
   logic           q_deque_max_req_ready;
   logic           q_deque_max_en;
   logic           q_deque_max_ready;
   logic [IDW-1:0] q_deque_max_ooo_flow_id;
   logic [PW-1:0]  q_deque_max_priority;
   logic [SW-1:0]  q_queue_size;
   logic           out_service_valid;
   logic [IDW-1:0] out_service_ooo_flow_id;
   logic [PW-1:0]  out_service_priority;
   logic           out_service_ready;
   logic           out_evict_valid;
   logic [IDW-1:0] out_evict_ooo_flow_id;
   logic [PW-1:0]  out_evict_priority;
   logic           out_evict_ready;
   logic [31:0]    evict_count;
   logic [15:0]    dropped_count;
   logic           timeout_err;

   ooo_flow_queue_driver #(
      .MAX_NUM_OOO_FLOWS(MAXF), .OOO_FLOW_ID_AWIDTH(IDW), .HEAP_PRIORITY_AWIDTH(PW),
      .HEAP_SIZE_AWIDTH(SW), .EVICT_THRESHOLD(THR), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .in_insert_valid(in_insert_valid), .in_insert_ooo_flow_id(in_insert_ooo_flow_id),
      .in_insert_priority(in_insert_priority), .in_insert_ready(in_insert_ready),
      .in_evict_req(in_evict_req),
      .q_enque_en(q_enque_en), .q_enque_ooo_flow_id(q_enque_ooo_flow_id),
      .q_enque_priority(q_enque_priority), .q_enque_ready(q_enque_ready),
      .q_deque_min_en(q_deque_min_en), .q_deque_min_ready(q_deque_min_ready),
      .q_deque_min_ooo_flow_id(q_deque_min_ooo_flow_id), .q_deque_min_priority(q_deque_min_priority),
      .q_deque_max_req_en(q_deque_max_req_en), .q_deque_max_req_ready(q_deque_max_req_ready),
      .q_deque_max_en(q_deque_max_en), .q_deque_max_ready(q_deque_max_ready),
      .q_deque_max_ooo_flow_id(q_deque_max_ooo_flow_id), .q_deque_max_priority(q_deque_max_priority),
      .q_queue_size(q_queue_size),
      .out_service_valid(out_service_valid), .out_service_ooo_flow_id(out_service_ooo_flow_id),
      .out_service_priority(out_service_priority), .out_service_ready(out_service_ready),
      .out_evict_valid(out_evict_valid), .out_evict_ooo_flow_id(out_evict_ooo_flow_id),
      .out_evict_priority(out_evict_priority), .out_evict_ready(out_evict_ready),
      .evict_count(evict_count), .dropped_count(dropped_count), .timeout_err(timeout_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard state: expected entries in order, plus a simple heap-side responder for deque-max.
   logic [15:0] svc_exp[$];
   logic [15:0] ev_exp[$];
   bit          mon_en = 1'b0;
   int          exp_ev_cnt = 0;
   bit          mx_out = 1'b0;
   bit          mx_on = 1'b0;
   int          mx_delay = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("enq_en", 32'(q_enque_en), 32'(in_insert_valid & q_enque_ready));
         if (q_enque_en)
            chk("enq_data", 32'({q_enque_ooo_flow_id, q_enque_priority}),
                32'({in_insert_ooo_flow_id, in_insert_priority}));
         chk("min_en", 32'(q_deque_min_en),
             32'(q_deque_min_ready & (~out_service_valid | out_service_ready)));
         chk("svc_occ", 32'(out_service_valid), 32'(svc_exp.size()));
         if (out_service_valid && svc_exp.size() != 0) begin
            chk("svc_data", 32'({out_service_ooo_flow_id, out_service_priority}), 32'(svc_exp[0]));
            if (out_service_ready) void'(svc_exp.pop_front());
         end
         if (q_deque_min_en) svc_exp.push_back({q_deque_min_ooo_flow_id, q_deque_min_priority});

         chk("max_overlap", 32'(q_deque_max_req_en & (q_deque_max_en | q_deque_max_ready)), 32'd0);
         chk("evict_count", evict_count, 32'(exp_ev_cnt));
         chk("dropped_rand", 32'(dropped_count), 32'd0);
         chk("ev_occ", 32'(out_evict_valid), 32'(ev_exp.size()));
         if (out_evict_valid && ev_exp.size() != 0) begin
            chk("ev_data", 32'({out_evict_ooo_flow_id, out_evict_priority}), 32'(ev_exp[0]));
            if (out_evict_ready) begin
               void'(ev_exp.pop_front());
               exp_ev_cnt++;
            end
         end
         if (q_deque_max_en && q_deque_max_ready && mx_on) begin
            ev_exp.push_back({q_deque_max_ooo_flow_id, q_deque_max_priority});
            mx_out = 1'b0;
            mx_on  = 1'b0;
         end
         if (q_deque_max_req_en && q_deque_max_req_ready) begin
            chk("req_dup", 32'(mx_out), 32'd0);
            mx_out   = 1'b1;
            mx_delay = $urandom_range(0, 3);
         end
      end
   end

   task automatic clear_inputs();
      in_insert_valid = 0; in_insert_ooo_flow_id = 0; in_insert_priority = 0;
      in_evict_req = 0; q_enque_ready = 0;
      q_deque_min_ready = 0; q_deque_min_ooo_flow_id = 0; q_deque_min_priority = 0;
      q_deque_max_req_ready = 0; q_deque_max_ready = 0;
      q_deque_max_ooo_flow_id = 0; q_deque_max_priority = 0;
      q_queue_size = 0; out_service_ready = 0; out_evict_ready = 0;
   endtask

   task automatic rand_drive(input bit drain);
      in_insert_valid       = drain ? 1'b0 : 1'($urandom);
      in_insert_ooo_flow_id = IDW'($urandom);
      in_insert_priority    = PW'($urandom);
      q_enque_ready         = 1'($urandom);
      q_deque_min_ready     = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
      q_deque_min_ooo_flow_id = IDW'($urandom);
      q_deque_min_priority  = PW'($urandom);
      out_service_ready     = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      out_evict_ready       = drain ? 1'b1 : 1'($urandom);
      q_queue_size          = drain ? '0 : SW'($urandom_range(0, MAXF));
      in_evict_req          = drain ? 1'b0 : ($urandom_range(0, 19) == 0);
      q_deque_max_req_ready = drain ? 1'b1 : 1'($urandom);
      if (mx_out && !mx_on) begin
         if (mx_delay == 0) begin
            mx_on = 1'b1;
            q_deque_max_ooo_flow_id = IDW'($urandom);
            q_deque_max_priority    = PW'($urandom);
         end else begin
            mx_delay--;
         end
      end
      q_deque_max_ready = mx_on;
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      // Reset: every enable must stay low even with all request inputs active.
      in_insert_valid = 1; q_enque_ready = 1; q_deque_min_ready = 1; q_deque_max_ready = 1;
      q_deque_max_req_ready = 1; q_queue_size = SW'(MAXF); in_evict_req = 1;
      tick(); tick();
      chk("rst_enq_en", 32'(q_enque_en), 0);
      chk("rst_ins_rdy", 32'(in_insert_ready), 0);
      chk("rst_min_en", 32'(q_deque_min_en), 0);
      chk("rst_req_en", 32'(q_deque_max_req_en), 0);
      chk("rst_max_en", 32'(q_deque_max_en), 0);
      chk("rst_svc_v", 32'(out_service_valid), 0);
      chk("rst_ev_v", 32'(out_evict_valid), 0);
      chk("rst_ids", 32'({out_service_ooo_flow_id, out_service_priority, out_evict_ooo_flow_id, out_evict_priority}), 0);
      chk("rst_ev_cnt", evict_count, 0);
      chk("rst_drop", 32'(dropped_count), 0);
      chk("rst_tmo", 32'(timeout_err), 0);
      clear_inputs();
      tick();
      rst = 0;
      tick();

      // Enque pass-through.
      in_insert_valid = 1; in_insert_ooo_flow_id = 5; in_insert_priority = 9; q_enque_ready = 1;
      #1;
      chk("enq_en_d", 32'(q_enque_en), 1);
      chk("enq_id_d", 32'(q_enque_ooo_flow_id), 5);
      chk("enq_pr_d", 32'(q_enque_priority), 9);
      chk("ins_rdy_d", 32'(in_insert_ready), 1);
      q_enque_ready = 0;
      #1;
      chk("ins_rdy_0", 32'(in_insert_ready), 0);
      chk("enq_en_0", 32'(q_enque_en), 0);
      clear_inputs();

      // Service path with backpressure.
      tick();
      q_deque_min_ready = 1; q_deque_min_ooo_flow_id = 3; q_deque_min_priority = 4;
      #1;
      chk("min_en_1", 32'(q_deque_min_en), 1);
      tick();
      q_deque_min_ooo_flow_id = 11; q_deque_min_priority = 12;
      #1;
      for (int i = 0; i < 10; i++) begin
         chk("svc_hold_v", 32'(out_service_valid), 1);
         chk("svc_hold_id", 32'(out_service_ooo_flow_id), 3);
         chk("svc_no_take", 32'(q_deque_min_en), 0);
         tick();
      end
      out_service_ready = 1;
      #1;
      chk("min_en_2", 32'(q_deque_min_en), 1);
      tick();
      q_deque_min_ready = 0;
      #1;
      chk("svc_b2b_v", 32'(out_service_valid), 1);
      chk("svc_b2b_id", 32'({out_service_ooo_flow_id, out_service_priority}), 32'({8'd11, 8'd12}));
      tick();
      chk("svc_clr", 32'(out_service_valid), 0);
      out_service_ready = 0;

      // Threshold eviction, forced request during HOLD, IDLE gap between evictions.
      q_queue_size = 10; #1; chk("thr_10", 32'(q_deque_max_req_en), 0);
      tick(); q_queue_size = 11; #1; chk("thr_11", 32'(q_deque_max_req_en), 0);
      tick(); q_queue_size = 12; #1; chk("thr_idle", 32'(q_deque_max_req_en), 0);
      tick();
      chk("thr_req", 32'(q_deque_max_req_en), 1);
      chk("thr_req_max", 32'(q_deque_max_en), 0);
      tick();
      chk("req_hold", 32'(q_deque_max_req_en), 1);
      q_deque_max_req_ready = 1;
      tick();
      q_deque_max_req_ready = 0; q_queue_size = 0;
      #1;
      chk("wait_req", 32'(q_deque_max_req_en), 0);
      chk("wait_max", 32'(q_deque_max_en), 1);
      tick();
      chk("wait_max2", 32'(q_deque_max_en), 1);
      q_deque_max_ready = 1; q_deque_max_ooo_flow_id = 7; q_deque_max_priority = 20;
      tick();
      q_deque_max_ready = 0;
      #1;
      chk("ev_v1", 32'(out_evict_valid), 1);
      chk("ev_id1", 32'({out_evict_ooo_flow_id, out_evict_priority}), 32'({8'd7, 8'd20}));
      chk("ev_cnt0", evict_count, 0);
      in_evict_req = 1;
      tick();
      in_evict_req = 0;
      #1;
      chk("hold_id", 32'(out_evict_ooo_flow_id), 7);
      chk("hold_req", 32'(q_deque_max_req_en), 0);
      out_evict_ready = 1;
      tick();
      out_evict_ready = 0;
      #1;
      chk("ev_cnt1", evict_count, 1);
      chk("ev_v_clr", 32'(out_evict_valid), 0);
      chk("idle_gap", 32'(q_deque_max_req_en), 0);
      tick();
      chk("pend_req", 32'(q_deque_max_req_en), 1);
      q_deque_max_req_ready = 1;
      tick();
      q_deque_max_req_ready = 0;
      q_deque_max_ready = 1; q_deque_max_ooo_flow_id = 8; q_deque_max_priority = 2;
      tick();
      q_deque_max_ready = 0;
      #1;
      chk("ev_id2", 32'({out_evict_ooo_flow_id, out_evict_priority}), 32'({8'd8, 8'd2}));
      out_evict_ready = 1;
      tick();
      out_evict_ready = 0;
      #1;
      chk("ev_cnt2", evict_count, 2);
      tick();
      chk("idle_stay", 32'(q_deque_max_req_en), 0);

      // Reset in WAIT, then a late response is dropped in IDLE.
      in_evict_req = 1; tick(); in_evict_req = 0; tick();
      q_deque_max_req_ready = 1; tick(); q_deque_max_req_ready = 0;
      #1;
      chk("w_max_en", 32'(q_deque_max_en), 1);
      rst = 1; tick(); rst = 0;
      #1;
      chk("rw_max_en", 32'(q_deque_max_en), 0);
      chk("rw_cnt", evict_count, 0);
      tick(); tick();
      q_deque_max_ready = 1; q_deque_max_ooo_flow_id = 44; q_deque_max_priority = 3;
      #1;
      chk("stale_en", 32'(q_deque_max_en), 1);
      chk("stale_req", 32'(q_deque_max_req_en), 0);
      tick();
      q_deque_max_ready = 0;
      #1;
      chk("drop1", 32'(dropped_count), 1);
      chk("stale_ev_v", 32'(out_evict_valid), 0);
      q_queue_size = 12; q_deque_max_ready = 1;
      tick();
      q_deque_max_ready = 0;
      #1;
      chk("drop_block", 32'(q_deque_max_req_en), 0);
      chk("drop2", 32'(dropped_count), 2);
      tick();
      chk("drop_then_req", 32'(q_deque_max_req_en), 1);
      q_deque_max_req_ready = 1; tick(); q_deque_max_req_ready = 0; q_queue_size = 0;
      q_deque_max_ready = 1; q_deque_max_ooo_flow_id = 50; q_deque_max_priority = 6;
      tick(); q_deque_max_ready = 0;
      #1;
      chk("ev_id3", 32'({out_evict_ooo_flow_id, out_evict_priority}), 32'({8'd50, 8'd6}));
      out_evict_ready = 1; tick(); out_evict_ready = 0;
      #1;
      chk("ev_cnt3", evict_count, 1);

      // Watchdog behaviour with no deque-max response.
      in_evict_req = 1; tick(); in_evict_req = 0; tick();
      q_deque_max_req_ready = 1; tick(); q_deque_max_req_ready = 0;
      #1;
`ifdef OOO_DRIVER_TIMEOUT_EN
      for (int i = 0; i < TMO - 1; i++) begin
         tick();
         chk("tmo_wait", 32'(q_deque_max_en), 1);
         chk("tmo_early", 32'(timeout_err), 0);
      end
      tick();
      chk("tmo_err", 32'(timeout_err), 1);
      chk("tmo_idle", 32'(q_deque_max_en), 0);
`else
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("nt_wait", 32'(q_deque_max_en), 1);
         chk("nt_err", 32'(timeout_err), 0);
      end
`endif
      rst = 1; tick(); tick(); rst = 0;
      #1;
      chk("tmo_rst", 32'(timeout_err), 0);

      // Randomized concurrent traffic against the scoreboard.
      exp_ev_cnt = 0;
      mon_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         rand_drive(1'b0);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         rand_drive(1'b1);
      end
      tick();
      mon_en = 1'b0;
      chk("svc_drained", 32'(svc_exp.size()), 0);
      chk("ev_drained", 32'(ev_exp.size()), 0);
      chk("ev_seen", 32'(exp_ev_cnt != 0), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
